// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared definitions for the DES CPU-bus sequencer: register indices, CTRL and
// STATUS bit positions, and the sequencer state encoding.
// -----------------------------------------------------------------------------
package des_pkg;

  // Register indices on the 3-bit CPU address bus
  localparam logic [2:0] ADDR_DATA_HI = 3'd0;  // plaintext[1:32]
  localparam logic [2:0] ADDR_DATA_LO = 3'd1;  // plaintext[33:64]
  localparam logic [2:0] ADDR_KEY_HI  = 3'd2;  // key[1:32]
  localparam logic [2:0] ADDR_KEY_LO  = 3'd3;  // key[33:64]
  localparam logic [2:0] ADDR_CTRL    = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;
  localparam logic [2:0] ADDR_RES_HI  = 3'd6;  // result[1:32]
  localparam logic [2:0] ADDR_RES_LO  = 3'd7;  // result[33:64]

  // CTRL write-word bit positions
  localparam int CTRL_START      = 0;  // self-clearing
  localparam int CTRL_DECRYPT    = 1;
  localparam int CTRL_CLEAR_DONE = 2;  // self-clearing
  localparam int CTRL_IRQ_EN     = 3;

  // CTRL read-word bit positions (the read layout packs irq_en next to decrypt)
  localparam int CTRL_RD_DECRYPT = 1;
  localparam int CTRL_RD_IRQ_EN  = 2;

  // STATUS bit positions (read); a STATUS write with STATUS_ERR set clears err
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/des_lat_counter.sv
// -----------------------------------------------------------------------------
// des_lat_counter
// Loadable down-counter with a zero flag. Counts the core latency while the
// sequencer is in RUN. Decrementing stops at zero.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val this cycle (has priority over dec)
//   load_val    value to load
//   dec         decrement by one when non-zero
//   zero        count is zero
// -----------------------------------------------------------------------------
module des_lat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/des_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// des_cpu_ctrl
// Memory-mapped sequencer between the CPU bus and an external DES core. Holds
// operand and key halves, starts the core on command, waits LATENCY cycles,
// captures the 64-bit result and reports busy/done/err status.
//
// Parameters:
//   LATENCY  cycles from des_start to a valid des_result (1..255)
//   CNT_W    latency counter width, 2**CNT_W > LATENCY
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en, rd_en    CPU write / read strobes
//   addr, wdata     register index, write data
//   rdata           registered read data (holds when rd_en is low)
//   busy            operation in progress
//   irq             done AND irq_en (level)
//   des_plaintext   operand to core, bit 63 = DES bit 1
//   des_key         key to core, bit 63 = DES bit 1
//   des_decrypt     mode to core, 0 = encrypt
//   des_start       one-cycle start pulse to core
//   des_result      core output, bit 63 = DES bit 1
// -----------------------------------------------------------------------------
module des_cpu_ctrl
  import des_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        irq,
  output logic [63:0] des_plaintext,
  output logic [63:0] des_key,
  output logic        des_decrypt,
  output logic        des_start,
  input  logic [63:0] des_result
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  state_t      state;
  logic [63:0] data_q;
  logic [63:0] key_q;
  logic [63:0] res_q;
  logic        decrypt_q;
  logic        irq_en_q;
  logic        done_q;
  logic        err_q;
  logic        cnt_zero;

  // Bus decode
  logic        in_run;
  logic        wr_operand;
  logic        wr_ctrl;
  logic        wr_status;
  logic        start_req;
  logic        start_ok;
  logic        clear_ok;
  logic        err_set;
  logic [31:0] rd_word;

  assign in_run     = (state == RUN);
  assign wr_operand = wr_en && !addr[2];  // addresses 0..3
  assign wr_ctrl    = wr_en && (addr == ADDR_CTRL);
  assign wr_status  = wr_en && (addr == ADDR_STATUS);
  assign start_req  = wr_ctrl && wdata[CTRL_START];
  assign start_ok   = start_req && !in_run;
  assign clear_ok   = wr_ctrl && wdata[CTRL_CLEAR_DONE] && !in_run;
  // Operand or start writes while running are dropped and flagged
  assign err_set    = in_run && (wr_operand || start_req);

  des_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .load_val (LOAD_VAL),
    .dec      (in_run),
    .zero     (cnt_zero)
  );

  // NOTE: default assignment first so no path leaves rd_word unassigned (no latch).
  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_DATA_HI: rd_word = data_q[63:32];
      ADDR_DATA_LO: rd_word = data_q[31:0];
      ADDR_KEY_HI:  rd_word = key_q[63:32];
      ADDR_KEY_LO:  rd_word = key_q[31:0];
      ADDR_CTRL: begin
        rd_word[CTRL_RD_DECRYPT] = decrypt_q;
        rd_word[CTRL_RD_IRQ_EN]  = irq_en_q;
      end
      ADDR_STATUS: begin
        rd_word[STATUS_BUSY] = busy;
        rd_word[STATUS_DONE] = done_q;
        rd_word[STATUS_ERR]  = err_q;
      end
      ADDR_RES_HI:  rd_word = res_q[63:32];
      ADDR_RES_LO:  rd_word = res_q[31:0];
      default:      rd_word = '0;
    endcase
  end

  // Register file, status flags and sequencer in one clocked block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand/key/result are plain flops, not RAM, so they reset with the control state.
      state     <= IDLE;
      data_q    <= '0;
      key_q     <= '0;
      res_q     <= '0;
      decrypt_q <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy      <= 1'b0;
      des_start <= 1'b0;
      rdata     <= '0;
    end else begin
      des_start <= start_ok;

      // Reads sample the pre-write register values
      if (rd_en) begin
        rdata <= rd_word;
      end

      // Operands and mode stay frozen for the whole of RUN
      if (wr_operand && !in_run) begin
        case (addr)
          ADDR_DATA_HI: data_q[63:32] <= wdata;
          ADDR_DATA_LO: data_q[31:0]  <= wdata;
          ADDR_KEY_HI:  key_q[63:32]  <= wdata;
          default:      key_q[31:0]   <= wdata;
        endcase
      end

      if (wr_ctrl && !in_run) begin
        decrypt_q <= wdata[CTRL_DECRYPT];
        irq_en_q  <= wdata[CTRL_IRQ_EN];
      end

      if (err_set) begin
        err_q <= 1'b1;
      end else if (wr_status && wdata[STATUS_ERR]) begin
        err_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_ok) begin
            state  <= RUN;
            busy   <= 1'b1;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_zero) begin
            res_q  <= des_result;
            done_q <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          // start has priority over clear_done in the same word
          if (start_ok) begin
            state  <= RUN;
            busy   <= 1'b1;
            done_q <= 1'b0;
          end else if (clear_ok) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign irq           = done_q && irq_en_q;
  assign des_plaintext = data_q;
  assign des_key       = key_q;
  assign des_decrypt   = decrypt_q;

endmodule

// File: tb/tb_des_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_des_cpu_ctrl
// Two sequencer instances: LATENCY=1 behind a fixed-vector core stub, and
// LATENCY=5 behind a stub whose output moves every cycle. A behavioural model
// tracks each instance from bus operations and the cycle count: busy/done are
// derived from the start edge plus latency, the expected result from the stub.
// -----------------------------------------------------------------------------
module tb_des_cpu_ctrl;
  import des_pkg::*;

  localparam int LAT0 = 1;
  localparam int LAT1 = 5;
  localparam logic [63:0] VEC_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] VEC_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] VEC_CT  = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en [2];
  logic        rd_en [2];
  logic [2:0]  addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        busy [2];
  logic        irq [2];
  logic        des_decrypt [2];
  logic        des_start [2];
  logic [63:0] des_plaintext [2];
  logic [63:0] des_key [2];
  logic [63:0] des_result [2];

  logic [31:0] cyc = '0;  // number of rising edges so far
  int n_cmp = 0;
  int n_err = 0;
  int start_seen [2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (des_start[0]) start_seen[0] <= start_seen[0] + 1;
    if (des_start[1]) start_seen[1] <= start_seen[1] + 1;
  end

  // Core stubs
  function automatic logic [63:0] core_fixed(logic [63:0] pt, logic [63:0] key, logic dec);
    if (key == VEC_KEY && !dec && pt == VEC_PT) return VEC_CT;
    if (key == VEC_KEY && dec && pt == VEC_CT) return VEC_PT;
    return {pt[31:0], pt[63:32]} ^ key ^ {64{dec}};
  endfunction

  function automatic logic [63:0] core_moving(logic [31:0] c, logic [63:0] pt);
    return {c, ~c} ^ pt;
  endfunction

  assign des_result[0] = core_fixed(des_plaintext[0], des_key[0], des_decrypt[0]);
  assign des_result[1] = core_moving(cyc, des_plaintext[1]);

  des_cpu_ctrl #(.LATENCY(LAT0), .CNT_W(8)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .busy(busy[0]), .irq(irq[0]),
    .des_plaintext(des_plaintext[0]), .des_key(des_key[0]), .des_decrypt(des_decrypt[0]),
    .des_start(des_start[0]), .des_result(des_result[0])
  );

  des_cpu_ctrl #(.LATENCY(LAT1), .CNT_W(8)) u_lat5 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .busy(busy[1]), .irq(irq[1]),
    .des_plaintext(des_plaintext[1]), .des_key(des_key[1]), .des_decrypt(des_decrypt[1]),
    .des_start(des_start[1]), .des_result(des_result[1])
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [63:0] m_data [2];
  logic [63:0] m_key [2];
  logic [63:0] m_res [2];
  logic [63:0] m_pend [2];
  logic        m_dec [2];
  logic        m_irqen [2];
  logic        m_err [2];
  logic        m_run [2];   // an operation was started and not yet cleared
  logic [31:0] m_start [2]; // edge number on which the start was accepted
  logic [31:0] m_rdata [2];
  int          m_starts [2] = '{0, 0};

  function automatic int lat(int s);
    return (s == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic m_busy(int s);
    return m_run[s] && (cyc < m_start[s] + 32'(lat(s)));
  endfunction

  function automatic logic m_done(int s);
    return m_run[s] && (cyc >= m_start[s] + 32'(lat(s)));
  endfunction

  function automatic logic [63:0] exp_res(int s);
    return m_done(s) ? m_pend[s] : m_res[s];
  endfunction

  function automatic logic [31:0] exp_read(int s, logic [2:0] a);
    logic [63:0] r;
    r = exp_res(s);
    case (a)
      3'd0:    return m_data[s][63:32];
      3'd1:    return m_data[s][31:0];
      3'd2:    return m_key[s][63:32];
      3'd3:    return m_key[s][31:0];
      3'd4:    return {29'b0, m_irqen[s], m_dec[s], 1'b0};
      3'd5:    return {29'b0, m_err[s], m_done(s), m_busy(s)};
      3'd6:    return r[63:32];
      default: return r[31:0];
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_data[s] = '0; m_key[s] = '0; m_res[s] = '0; m_pend[s] = '0;
      m_dec[s] = 1'b0; m_irqen[s] = 1'b0; m_err[s] = 1'b0; m_run[s] = 1'b0;
      m_start[s] = '0; m_rdata[s] = '0;
    end
  endtask

  // Called before the edge that samples the write
  task automatic model_write(int s, logic [2:0] a, logic [31:0] d);
    logic b;
    b = m_busy(s);
    if (a <= 3'd3) begin
      if (b) m_err[s] = 1'b1;
      else begin
        case (a)
          3'd0:    m_data[s][63:32] = d;
          3'd1:    m_data[s][31:0]  = d;
          3'd2:    m_key[s][63:32]  = d;
          default: m_key[s][31:0]   = d;
        endcase
      end
    end else if (a == 3'd4) begin
      if (b) begin
        if (d[0]) m_err[s] = 1'b1;
      end else begin
        m_dec[s]   = d[1];
        m_irqen[s] = d[3];
        if (d[0]) begin
          m_res[s]  = exp_res(s);
          m_run[s]  = 1'b1;
          m_start[s] = cyc + 1;
          m_starts[s]++;
          if (s == 0) m_pend[s] = core_fixed(m_data[s], m_key[s], m_dec[s]);
          else        m_pend[s] = core_moving(cyc + 32'(lat(s)), m_data[s]);
        end else if (d[2] && m_done(s)) begin
          m_res[s] = exp_res(s);
          m_run[s] = 1'b0;
        end
      end
    end else if (a == 3'd5) begin
      if (d[2]) m_err[s] = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking and bus tasks
  // ---------------------------------------------------------------------------
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(int s);
    check($sformatf("busy%0d", s), 64'(busy[s]), 64'(m_busy(s)));
    check($sformatf("irq%0d", s), 64'(irq[s]), 64'(m_done(s) && m_irqen[s]));
    check($sformatf("start%0d", s), 64'(des_start[s]), 64'(m_run[s] && (cyc == m_start[s])));
    check($sformatf("pt%0d", s), des_plaintext[s], m_data[s]);
    check($sformatf("key%0d", s), des_key[s], m_key[s]);
    check($sformatf("dec%0d", s), 64'(des_decrypt[s]), 64'(m_dec[s]));
    check($sformatf("rdata%0d", s), 64'(rdata[s]), 64'(m_rdata[s]));
  endtask

  // One bus cycle: drive at a falling edge, sample at the next falling edge
  task automatic bus_op(int s, bit w, bit r, logic [2:0] a, logic [31:0] d,
                        output logic [31:0] got);
    logic [31:0] exp_rd;
    exp_rd = exp_read(s, a);
    if (w) model_write(s, a, d);
    if (r) m_rdata[s] = exp_rd;
    wr_en[s] = w; rd_en[s] = r; addr[s] = a; wdata[s] = d;
    @(negedge clk);
    wr_en[s] = 1'b0; rd_en[s] = 1'b0;
    got = rdata[s];
    if (r) check($sformatf("rd%0d_a%0d", s, a), 64'(rdata[s]), 64'(exp_rd));
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic wr(int s, logic [2:0] a, logic [31:0] d);
    logic [31:0] unused_rd;
    bus_op(s, 1'b1, 1'b0, a, d, unused_rd);
  endtask

  task automatic rd(int s, logic [2:0] a, output logic [31:0] got);
    bus_op(s, 1'b0, 1'b1, a, 32'h0, got);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      check_outputs(0);
      check_outputs(1);
    end
  endtask

  task automatic read_all(int s);
    logic [31:0] got;
    for (int a = 0; a < 8; a++) rd(s, 3'(a), got);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] got;
    logic [31:0] hi_before;
    logic [31:0] c0;
    logic [63:0] exp_capture;
    int s;
    int op;
    logic [2:0] a;
    logic [31:0] d;

    for (int i = 0; i < 2; i++) begin
      wr_en[i] = 1'b0; rd_en[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy[1]), 64'd0);
    check("reset_rdata", 64'(rdata[1]), 64'd0);
    check_outputs(0);
    check_outputs(1);
    rst_n = 1'b1;
    idle(1);
    read_all(0);
    read_all(1);

    // Known encrypt vector, LATENCY=1, irq enabled
    wr(0, ADDR_DATA_HI, VEC_PT[63:32]);
    wr(0, ADDR_DATA_LO, VEC_PT[31:0]);
    wr(0, ADDR_KEY_HI, VEC_KEY[63:32]);
    wr(0, ADDR_KEY_LO, VEC_KEY[31:0]);
    wr(0, ADDR_CTRL, 32'h9);
    check("l1_busy_c1", 64'(busy[0]), 64'd1);
    idle(1);
    check("l1_busy_c2", 64'(busy[0]), 64'd0);
    check("l1_irq", 64'(irq[0]), 64'd1);
    rd(0, ADDR_RES_HI, got);
    check("enc_res_hi", 64'(got), 64'h85E81354);
    rd(0, ADDR_RES_LO, got);
    check("enc_res_lo", 64'(got), 64'h0F0AB405);
    rd(0, ADDR_STATUS, got);
    check("enc_status", 64'(got), 64'h2);

    // Decrypt back, started from DONE
    wr(0, ADDR_DATA_HI, VEC_CT[63:32]);
    wr(0, ADDR_DATA_LO, VEC_CT[31:0]);
    wr(0, ADDR_CTRL, 32'hB);
    idle(1);
    rd(0, ADDR_RES_HI, got);
    check("dec_res_hi", 64'(got), 64'h01234567);
    rd(0, ADDR_RES_LO, got);
    check("dec_res_lo", 64'(got), 64'h89ABCDEF);
    rd(0, ADDR_CTRL, got);
    check("ctrl_rd", 64'(got), 64'h6);

    // clear_done from DONE, then start+clear_done in one word (start wins)
    wr(0, ADDR_CTRL, 32'hC);
    rd(0, ADDR_STATUS, got);
    check("clr_status", 64'(got), 64'h0);
    check("clr_irq", 64'(irq[0]), 64'd0);
    wr(0, ADDR_CTRL, 32'h9);
    idle(1);
    wr(0, ADDR_CTRL, 32'hD);
    check("start_over_clear", 64'(busy[0]), 64'd1);
    idle(2);
    check("l1_start_count", 64'(start_seen[0]), 64'(m_starts[0]));

    // LATENCY=5: capture exactly on the 5th edge after the start edge
    wr(1, ADDR_DATA_HI, $urandom);
    wr(1, ADDR_DATA_LO, $urandom);
    wr(1, ADDR_KEY_HI, $urandom);
    wr(1, ADDR_KEY_LO, $urandom);
    c0 = cyc;
    exp_capture = core_moving(c0 + 32'(LAT1), m_data[1]);
    wr(1, ADDR_CTRL, 32'h1);
    for (int k = 1; k <= LAT1; k++) begin
      check($sformatf("l5_busy_c%0d", k), 64'(busy[1]), 64'd1);
      idle(1);
    end
    check("l5_busy_end", 64'(busy[1]), 64'd0);
    rd(1, ADDR_RES_HI, got);
    check("l5_cap_hi", 64'(got), 64'(exp_capture[63:32]));
    rd(1, ADDR_RES_LO, got);
    check("l5_cap_lo", 64'(got), 64'(exp_capture[31:0]));

    // Protected writes during RUN
    hi_before = m_data[1][63:32];
    wr(1, ADDR_CTRL, 32'h1);
    wr(1, ADDR_DATA_HI, 32'hFFFFFFFF);
    wr(1, ADDR_CTRL, 32'h1);
    rd(1, ADDR_STATUS, got);
    check("run_status", 64'(got), 64'h5);
    rd(1, ADDR_DATA_HI, got);
    check("run_data_hi", 64'(got), 64'(hi_before));
    idle(3);
    check("l5_start_count", 64'(start_seen[1]), 64'(m_starts[1]));
    wr(1, ADDR_STATUS, 32'h4);
    rd(1, ADDR_STATUS, got);
    check("err_cleared", 64'(got), 64'h2);

    // RO writes are ignored without err; write+read in one cycle returns old value
    wr(1, ADDR_RES_HI, 32'hDEADBEEF);
    rd(1, ADDR_STATUS, got);
    check("ro_no_err", 64'(got), 64'h2);
    bus_op(1, 1'b1, 1'b1, ADDR_DATA_LO, 32'hCAFEF00D, got);
    rd(1, ADDR_DATA_LO, got);
    check("wr_then_rd", 64'(got), 64'hCAFEF00D);

    // Randomized bus traffic on both instances
    for (int i = 0; i < 300; i++) begin
      s  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      a  = 3'($urandom_range(0, 7));
      d  = (a == ADDR_CTRL) ? 32'($urandom_range(0, 15)) : $urandom;
      if (op <= 3)      wr(s, a, d);
      else if (op <= 6) rd(s, a, got);
      else if (op == 7) bus_op(s, 1'b1, 1'b1, a, d, got);
      else              idle(1);
    end
    idle(LAT1 + 1);
    check("rand_start_count0", 64'(start_seen[0]), 64'(m_starts[0]));
    check("rand_start_count1", 64'(start_seen[1]), 64'(m_starts[1]));

    // Reset in the middle of a LATENCY=5 run
    wr(1, ADDR_STATUS, 32'h4);
    wr(1, ADDR_CTRL, 32'hD);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_busy", 64'(busy[1]), 64'd0);
    check("rst_irq", 64'(irq[1]), 64'd0);
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT1 + 3);
    read_all(1);
    read_all(0);

    // Start from IDLE after reset still works
    wr(1, ADDR_CTRL, 32'h1);
    idle(LAT1);
    rd(1, ADDR_STATUS, got);
    check("post_rst_done", 64'(got), 64'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/des_cpu_ctrl.md
Name: des_cpu_ctrl

Overview:
Memory-mapped sequencer between the MIPS CPU bus and the DES datapath core. It holds the plaintext and key halves the CPU writes, and starts an operation on command. It waits a fixed core latency, captures the 64-bit result and reports busy/done/error status. It replaces decision-code steering with a clocked register file plus FSM, so operand loading, execution and readback are ordered and protected.

Parameters:
LATENCY, 1, clock cycles from des_start to a valid des_result (1 = combinational core registered once); legal range 1..255
CNT_W, 8, width of the latency counter; must satisfy 2^CNT_W > LATENCY

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  CPU write strobe, one cycle per write
rd_en  input  1  CPU read strobe
addr  input  3  register index
wdata  input  32  CPU write data
rdata  output  32  CPU read data, registered
busy  output  1  operation in progress
irq  output  1  done AND irq_en, level
des_plaintext  output  64  [1:64] operand to core, bit 1 = MSB
des_key  output  64  [1:64] key to core
des_decrypt  output  1  mode to core, 0 = encrypt
des_start  output  1  one-cycle start pulse to core
des_result  input  64  [1:64] core output

Behaviour:
- Register map: 0 DATA_HI = plaintext[1:32], R/W; 1 DATA_LO = [33:64], R/W; 2 KEY_HI, R/W; 3 KEY_LO, R/W.
- 4 CTRL, write: bit0 start (self-clearing), bit1 decrypt, bit2 clear_done (self-clearing), bit3 irq_en. Read returns {29'b0, irq_en, decrypt, 1'b0}.
- 5 STATUS, read-only: bit0 busy, bit1 done, bit2 err (sticky). A write with wdata[2]=1 clears err.
- 6 RES_HI = result[1:32], RO; 7 RES_LO = result[33:64], RO.
- Reset: all operand, key and result registers 0. decrypt, irq_en, done and err are 0. FSM is IDLE; rdata, des_start, busy and irq are 0.
- FSM states:
  - IDLE: a start write moves to RUN. It pulses des_start in the same cycle as entering RUN and loads cnt = LATENCY-1. busy=1 from the next cycle. done=0.
  - RUN: cnt decrements each cycle. When cnt==0, the result register captures des_result, done=1 and the state goes to DONE. Total start-write to done=1 is LATENCY+1 edges.
  - DONE: busy=0. A start write re-enters RUN (done cleared). clear_done returns to IDLE with done=0.
- While busy: writes to addr 0-3 or start are ignored and set err. CTRL bits 1/3 writes are also ignored. Reads are always honoured.
- A start write with clear_done also set in the same word: start wins and done is cleared.
- rdata updates on the clock edge after rd_en and holds its value otherwise. Unmapped read bits are 0. wr_en and rd_en may both be high in the same cycle: the read returns the pre-write value.
- des_plaintext, des_key and des_decrypt are driven directly from registers and are stable for the whole of RUN.
- Reset asserted mid-RUN: immediate return to reset values. No result is captured.
- Writes to RO addresses 6/7 are ignored and do not set err.

Decomposition:
- Shared package des_pkg holds:
  - register index constants (ADDR_DATA_HI .. ADDR_RES_LO);
  - CTRL/STATUS bit positions;
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One natural sub-module: des_lat_counter, a loadable down-counter with a zero flag, used by the RUN state.
- The DES core is instantiated outside this block, by the integrating top.

Test Plan:
- Key 133457799BBCDFF1, plaintext 0123456789ABCDEF, start encrypt, with the real core and LATENCY=1. Expected: busy for 1 cycle, done after 2 edges, RES_HI=85E81354, RES_LO=0F0AB405, irq=1 with irq_en set.
- Same key, plaintext 85E813540F0AB405, decrypt=1. Expected: result 0123456789ABCDEF.
- LATENCY=5 with a stub core that changes des_result each cycle. Expected: captured value equals the stub output at exactly the 5th edge after the start edge; busy=1 for 5 cycles.
- During RUN, write DATA_HI=FFFFFFFF and start again. Expected: DATA_HI readback unchanged, STATUS=0x5 (busy, err), single des_start pulse only. Then write STATUS 0x4: err=0.
- Assert rst_n=0 at cycle 2 of a LATENCY=5 run. Expected: immediate busy=0, done=0, all registers read 0, and no capture after release.
- In DONE, write clear_done. Expected: STATUS=0x0, irq=0. A start from DONE produces a new des_start pulse and done re-asserts after LATENCY+1 edges.
